// File: rtl/hist_pkg.sv
// Shared definitions for the histogram / CDF builder: FSM encoding and default widths.
package hist_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int CNT_W_DEF      = 32;
    localparam int BINS_DEF       = 2 ** PIX_W_DEF;
    localparam int PIXELS_DEF     = 76800;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_READY = 2'd3
    } state_t;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port bin RAM: one write port, one synchronous read port, read-before-write.
module hist_ram
    import hist_pkg::*;
#(
    parameter int ADDR_W = PIX_W_DEF,
    parameter int DATA_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // A read and a write to the same bin on one edge return the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hist_cdf_builder.sv
// Builds a per-frame grey-level histogram, converts it in place to a CDF, captures cdf_min
// and serves (cdf, cdf_min) lookups to the downstream equaliser.
module hist_cdf_builder
    import hist_pkg::*;
#(
    parameter int PIXELS_PER_FRAME = PIXELS_DEF,
    parameter int PIX_W            = PIX_W_DEF,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic             pix_ready,
    input  logic             next_frame,
    input  logic             lut_valid,
    input  logic [PIX_W-1:0] lut_addr,
    output logic [CNT_W-1:0] cdf_out,
    output logic [CNT_W-1:0] cdf_min,
    output logic             lut_out_valid,
    output logic             cdf_ready,
    output logic             degenerate
);

    localparam int               BINS      = 2 ** PIX_W;
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(PIXELS_PER_FRAME);
    localparam logic [PIX_W:0]   LAST_BIN  = (PIX_W + 1)'(BINS - 1);
    localparam logic [PIX_W:0]   ALL_BINS  = (PIX_W + 1)'(BINS);

    state_t             state;
    state_t             state_nxt;
    logic [PIX_W:0]     idx;
    logic [CNT_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   run_sum;
    logic [CNT_W-1:0]   sum_nxt;
    logic [CNT_W-1:0]   cdf_hold;

    logic               accept;
    logic               scan_issue;
    logic               fwd;
    logic               vld_p1;
    logic               vld_p2;
    logic [PIX_W-1:0]   addr_p1;
    logic [PIX_W-1:0]   addr_p2;
    logic [CNT_W-1:0]   inc_p1;
    logic [CNT_W-1:0]   data_p2;

    logic               ram_we;
    logic [PIX_W-1:0]   ram_waddr;
    logic [CNT_W-1:0]   ram_wdata;
    logic               ram_re;
    logic [PIX_W-1:0]   ram_raddr;
    logic [CNT_W-1:0]   ram_rdata;

    hist_ram #(
        .ADDR_W (PIX_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign pix_ready  = (state == ST_ACCUM) && (pix_cnt != FRAME_PIX);
    assign accept     = pix_valid && pix_ready;
    assign scan_issue = (state == ST_SCAN) && !idx[PIX_W];
    assign cdf_ready  = (state == ST_READY);
    assign degenerate = cdf_ready && (cdf_min == FRAME_PIX);
    assign cdf_out    = lut_out_valid ? ram_rdata : cdf_hold;

    // p1: read data is back. The bin written on the previous edge was read stale, so take it from p2.
    assign fwd     = vld_p2 && (addr_p2 == addr_p1);
    assign inc_p1  = (fwd ? data_p2 : ram_rdata) + 1'b1;
    assign sum_nxt = run_sum + ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (idx == LAST_BIN)                      state_nxt = ST_ACCUM;
            ST_ACCUM: if ((pix_cnt == FRAME_PIX) && !vld_p1)     state_nxt = ST_SCAN;
            ST_SCAN:  if (idx == ALL_BINS)                      state_nxt = ST_READY;
            ST_READY: if (next_frame)                           state_nxt = ST_CLEAR;
            default:                                            state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = pix_in;
        ram_we    = 1'b0;
        ram_waddr = addr_p1;
        ram_wdata = inc_p1;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = idx[PIX_W-1:0];
                ram_wdata = '0;
            end
            ST_ACCUM: begin
                ram_re    = accept;
                ram_raddr = pix_in;
                ram_we    = vld_p1;
                ram_wdata = inc_p1;
            end
            ST_SCAN: begin
                ram_re    = scan_issue;
                ram_raddr = idx[PIX_W-1:0];
                ram_we    = vld_p1;
                ram_wdata = sum_nxt;
            end
            ST_READY: begin
                ram_re    = lut_valid;
                ram_raddr = lut_addr;
            end
            default: ;
        endcase
    end

    // Control: counters, pipeline valids and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= '0;
            pix_cnt       <= '0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            lut_out_valid <= 1'b0;
            cdf_min       <= '0;
            cdf_hold      <= '0;
        end else begin
            vld_p1        <= accept || scan_issue;
            vld_p2        <= (state == ST_ACCUM) && vld_p1;
            lut_out_valid <= (state == ST_READY) && lut_valid;
            if (lut_out_valid) begin
                cdf_hold <= ram_rdata;
            end
            case (state)
                ST_CLEAR: begin
                    idx     <= (idx == LAST_BIN) ? '0 : idx + 1'b1;
                    pix_cnt <= '0;
                end
                ST_ACCUM: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_issue) begin
                        idx <= idx + 1'b1;
                    end else if (idx == ALL_BINS) begin
                        idx <= '0;
                    end
                    if (vld_p1 && (cdf_min == '0) && (sum_nxt != '0)) begin
                        cdf_min <= sum_nxt;
                    end
                end
                ST_READY: begin
                    if (next_frame) begin
                        cdf_min <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // p2: record of the bin committed on this edge, used for forwarding.
    always_ff @(posedge clk) begin
        addr_p1 <= ram_raddr;
        addr_p2 <= addr_p1;
        data_p2 <= inc_p1;
        if (state == ST_CLEAR) begin
            run_sum <= '0;
        end else if ((state == ST_SCAN) && vld_p1) begin
            run_sum <= sum_nxt;
        end
    end

endmodule

// File: tb/tb_hist_cdf_builder.sv
// Scoreboard bench for hist_cdf_builder with a 16-pixel frame.
module tb_hist_cdf_builder;

    localparam int NPIX  = 16;
    localparam int PIX_W = 8;
    localparam int CNT_W = 32;
    localparam int BINS  = 256;

    typedef logic [7:0] frame_t [NPIX];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_ready;
    logic             next_frame = 1'b0;
    logic             lut_valid = 1'b0;
    logic [PIX_W-1:0] lut_addr = '0;
    logic [CNT_W-1:0] cdf_out;
    logic [CNT_W-1:0] cdf_min;
    logic             lut_out_valid;
    logic             cdf_ready;
    logic             degenerate;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cdf [BINS];
    int exp_min;
    int sb_q [$];
    int mon_exp;

    hist_cdf_builder #(
        .PIXELS_PER_FRAME (NPIX),
        .PIX_W            (PIX_W),
        .CNT_W            (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid     (pix_valid),
        .pix_in        (pix_in),
        .pix_ready     (pix_ready),
        .next_frame    (next_frame),
        .lut_valid     (lut_valid),
        .lut_addr      (lut_addr),
        .cdf_out       (cdf_out),
        .cdf_min       (cdf_min),
        .lut_out_valid (lut_out_valid),
        .cdf_ready     (cdf_ready),
        .degenerate    (degenerate)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every lookup response is matched against the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (lut_out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("lut_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check_val("cdf_out", cdf_out, mon_exp);
            end
        end
    end

    task automatic build_model(input frame_t px);
        int hist [BINS];
        int s;
        for (int b = 0; b < BINS; b++) hist[b] = 0;
        for (int i = 0; i < NPIX; i++) hist[px[i]]++;
        s = 0;
        exp_min = 0;
        for (int b = 0; b < BINS; b++) begin
            s = s + hist[b];
            exp_cdf[b] = s;
            if (exp_min == 0 && s != 0) exp_min = s;
        end
    endtask

    task automatic wait_accum(input string tag, input int exp_len);
        int n = 0;
        while (pix_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (pix_ready !== 1'b1) check_val({tag, "_accum_timeout"}, 32'd0, 32'd1);
        else check_val({tag, "_clear_len"}, n, exp_len);
    endtask

    task automatic send_pixels(input string tag, input frame_t px, input bit rnd);
        int  i = 0;
        int  guard = 0;
        bit  xfer;
        while (i < NPIX && guard < 1000) begin
            pix_in    = px[i];
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer      = pix_valid && (pix_ready === 1'b1);
            step();
            if (xfer) i++;
            guard++;
        end
        pix_valid = 1'b0;
        if (i < NPIX) check_val({tag, "_send_timeout"}, i, NPIX);
    endtask

    task automatic finish_frame(input string tag, input int req_min, input bit req_degen);
        int n = 0;
        while (cdf_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check_val({tag, "_cdf_ready"}, 32'(cdf_ready), 32'd1);
        check_val({tag, "_cdf_min"}, cdf_min, req_min);
        check_val({tag, "_model_min"}, cdf_min, exp_min);
        check_val({tag, "_degenerate"}, 32'(degenerate), 32'(req_degen));
        for (int a = 0; a < BINS; a++) begin
            lut_valid  = 1'b1;
            lut_addr   = 8'(a);
            next_frame = (a == BINS - 1);
            sb_q.push_back(exp_cdf[a]);
            step();
        end
        next_frame = 1'b0;
        check_val({tag, "_ready_drop"}, 32'(cdf_ready), 32'd0);
        check_val({tag, "_min_drop"}, cdf_min, 32'd0);
        // Lookups and next_frame during CLEAR must be ignored.
        lut_addr   = 8'd0;
        next_frame = 1'b1;
        step();
        step();
        lut_valid  = 1'b0;
        next_frame = 1'b0;
        step();
        wait_accum(tag, BINS - 3);
        check_val({tag, "_cdf_hold"}, cdf_out, NPIX);
        check_val({tag, "_sb_drain"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f_five;
        frame_t f_ramp;
        frame_t f_mix;
        frame_t f_nine;
        int     xfers;

        for (int i = 0; i < NPIX; i++) begin
            f_five[i] = 8'd5;
            f_ramp[i] = 8'(i);
            f_nine[i] = 8'd9;
        end
        f_mix = '{8'd200, 8'd200, 8'd3, 8'd200, 8'd3, 8'd3, 8'd200, 8'd200,
                  8'd200, 8'd3, 8'd3, 8'd3, 8'd200, 8'd200, 8'd3, 8'd3};

        rst_n = 1'b0;
        step();
        step();
        check_val("rst_pix_ready", 32'(pix_ready), 32'd0);
        check_val("rst_cdf_ready", 32'(cdf_ready), 32'd0);
        check_val("rst_cdf_min", cdf_min, 32'd0);
        check_val("rst_cdf_out", cdf_out, 32'd0);
        check_val("rst_lut_out_valid", 32'(lut_out_valid), 32'd0);
        check_val("rst_degenerate", 32'(degenerate), 32'd0);
        rst_n = 1'b1;
        wait_accum("rst", BINS);

        build_model(f_five);
        send_pixels("t1", f_five, 1'b0);
        finish_frame("t1", 16, 1'b1);

        build_model(f_ramp);
        send_pixels("t2", f_ramp, 1'b1);
        finish_frame("t2", 1, 1'b0);

        build_model(f_mix);
        send_pixels("t3", f_mix, 1'b0);
        finish_frame("t3", 8, 1'b0);

        // Valid held high past the frame length: only 16 may transfer.
        build_model(f_ramp);
        xfers = 0;
        for (int k = 0; k < 20; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(k);
            if (k >= NPIX) check_val("t4_ready_low", 32'(pix_ready), 32'd0);
            if (pix_ready === 1'b1) xfers++;
            step();
        end
        pix_valid = 1'b0;
        check_val("t4_xfers", xfers, NPIX);
        finish_frame("t4", 1, 1'b0);

        // Abort a frame mid-accumulation; nothing of it may survive.
        for (int k = 0; k < 7; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'd77;
            step();
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("t6_rst_pix_ready", 32'(pix_ready), 32'd0);
        check_val("t6_rst_cdf_ready", 32'(cdf_ready), 32'd0);
        wait_accum("t6", BINS);
        build_model(f_nine);
        check_val("t6_model_cdf9", exp_cdf[9], 32'd16);
        send_pixels("t6", f_nine, 1'b0);
        finish_frame("t6", 16, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
